// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: widths, reset/nop constants and the fetch FSM state type.
package riscv_pkg;
  localparam int               XLEN         = 32;
  localparam logic [31:0]      NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0]  RESET_PC_DEF = '0;

  typedef enum logic {
    REQ  = 1'b0,
    EXEC = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit (master) and the I-side memory (slave).
interface instr_fetch_unit_if #(
  parameter int AW = riscv_pkg::XLEN
);
  logic          req;
  logic [AW-1:0] addr;
  logic          ready;
  logic [31:0]   rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/pc_register.sv
// Program counter with synchronous reset, load enable and the sequential/redirect next-PC select.
module pc_register #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);
  logic [XLEN-1:0] pc_next;

  // Targets are word aligned: the two low bits of the target are cleared.
  assign pc_plus4 = pc + XLEN'(4);
  assign pc_next  = pc_src ? (pc_target & ~XLEN'(3)) : pc_plus4;

  always_ff @(posedge clk) begin
    if (reset)        pc <= RESET_PC;
    else if (load_en) pc <= pc_next;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding fetch stage: requests Instr at PC, holds it while it executes, then advances PC.
module instr_fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      PCSrc,
  input  logic [XLEN-1:0]           PCTarget,
  input  logic                      stall,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               Instr,
  output logic [XLEN-1:0]           PC,
  output logic [XLEN-1:0]           PCPlus4,
  output logic                      instr_valid,
  output logic [31:0]               instret
);
  import riscv_pkg::*;

  fetch_state_t state_q, state_d;
  logic         rst_hold_q;
  logic         fetch_done;
  logic         retire;

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .load_en   (retire),
    .pc_src    (PCSrc),
    .pc_target (PCTarget),
    .pc        (PC),
    .pc_plus4  (PCPlus4)
  );

  // Keeps imem_req low for the first cycle after reset so an abandoned transfer is seen as dropped.
  always_ff @(posedge clk) begin
    rst_hold_q <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     if (fetch_done) state_d = EXEC;
      EXEC:    if (!stall)     state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    imem.req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      REQ:     imem.req    = ~rst_hold_q;
      EXEC:    instr_valid = 1'b1;
      default: imem.req    = 1'b0;
    endcase
  end

  assign imem.addr  = PC;
  assign fetch_done = imem.req & imem.ready;
  assign retire     = instr_valid & ~stall;

  always_ff @(posedge clk) begin
    if (reset)           Instr <= NOP_INSTR;
    else if (fetch_done) Instr <= imem.rdata;
  end

  always_ff @(posedge clk) begin
    if (reset)       instret <= '0;
    else if (retire) instret <= instret + 32'd1;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch sequencing, miss, redirect, stall, PC wrap and reset abort.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc, stall;
  logic [31:0] PCTarget;
  logic [31:0] Instr, PC, PCPlus4, instret;
  logic        instr_valid;

  logic        w_stall;
  logic [31:0] w_Instr, w_PC, w_PCPlus4, w_instret;
  logic        w_instr_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.AW(32)) imem ();
  instr_fetch_unit_if #(.AW(32)) wmem ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
    .imem(imem.master), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .instr_valid(instr_valid), .instret(instret)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dutw (
    .clk(clk), .reset(reset), .PCSrc(1'b0), .PCTarget(32'h0), .stall(w_stall),
    .imem(wmem.master), .Instr(w_Instr), .PC(w_PC), .PCPlus4(w_PCPlus4),
    .instr_valid(w_instr_valid), .instret(w_instret)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; PCSrc = 1'b0; PCTarget = '0; stall = 1'b0;
    imem.ready = 1'b1; imem.rdata = 32'h0000_0093;
    w_stall = 1'b1; wmem.ready = 1'b1; wmem.rdata = 32'h0010_0113;

    // Test 1: reset state then three back-to-back hits
    step();
    check("rst_req", {31'd0, imem.req}, 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instr, 32'h0000_0013);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instret", instret, 32'd0);
    reset = 1'b0;
    step();
    check("t1_req0", {31'd0, imem.req}, 32'd1);
    check("t1_addr0", imem.addr, 32'h0);
    step();
    check("t1_valid0", {31'd0, instr_valid}, 32'd1);
    check("t1_instr0", Instr, 32'h0000_0093);
    check("t1_pcplus4", PCPlus4, 32'h4);
    check("t1_req_exec", {31'd0, imem.req}, 32'd0);
    imem.rdata = 32'h0020_0193;
    step();
    check("t1_addr1", imem.addr, 32'h4);
    check("t1_instret1", instret, 32'd1);
    step();
    check("t1_instr1", Instr, 32'h0020_0193);
    imem.rdata = 32'h0030_0213;
    step();
    check("t1_addr2", imem.addr, 32'h8);
    step();
    check("t1_instr2", Instr, 32'h0030_0213);
    imem.rdata = 32'h0040_0293;
    step();
    check("t1_addr3", imem.addr, 32'hC);
    check("t1_instret3", instret, 32'd3);
    step();
    imem.ready = 1'b0;
    imem.rdata = 32'hFFFF_FFFF;

    // Test 2: three-cycle miss at 0x10
    step();
    check("t2_instret", instret, 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("t2_addr_hold", imem.addr, 32'h10);
      check("t2_req_hold", {31'd0, imem.req}, 32'd1);
      check("t2_valid_lo", {31'd0, instr_valid}, 32'd0);
      step();
    end
    imem.ready = 1'b1;
    imem.rdata = 32'h0050_0093;
    check("t2_addr_last", imem.addr, 32'h10);
    step();
    check("t2_instr", Instr, 32'h0050_0093);
    check("t2_valid", {31'd0, instr_valid}, 32'd1);

    // Test 3: redirects (0x10 -> 0x20, then 0x20 -> 0x100 with low bits cleared)
    PCSrc = 1'b1; PCTarget = 32'h22;
    step();
    check("t3_addr20", imem.addr, 32'h20);
    PCSrc = 1'b0;
    imem.rdata = 32'h0060_0313;
    step();
    check("t3_pc20", PC, 32'h20);
    PCSrc = 1'b1; PCTarget = 32'h103;
    step();
    check("t3_addr100", imem.addr, 32'h100);
    check("t3_pcplus4", PCPlus4, 32'h104);
    check("t3_instret", instret, 32'd6);

    // Test 4: five stalled EXEC cycles with PCSrc toggling
    PCSrc = 1'b0;
    imem.rdata = 32'h0070_0393;
    stall = 1'b1;
    step();
    PCTarget = 32'h200;
    imem.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      PCSrc = i[0];
      check("t4_pc", PC, 32'h100);
      check("t4_instr", Instr, 32'h0070_0393);
      check("t4_instret", instret, 32'd6);
      check("t4_valid", {31'd0, instr_valid}, 32'd1);
      step();
    end
    check("t4_pc_end", PC, 32'h100);
    stall = 1'b0; PCSrc = 1'b0;
    step();
    check("t4_retire_pc", PC, 32'h104);
    check("t4_retire_cnt", instret, 32'd7);
    check("t4_retire_valid", {31'd0, instr_valid}, 32'd0);
    imem.ready = 1'b0;

    // Test 5: PC wrap on the second instance
    check("t5_waddr", wmem.addr, 32'hFFFF_FFFC);
    check("t5_wpc", w_PC, 32'hFFFF_FFFC);
    check("t5_wpcplus4", w_PCPlus4, 32'h0);
    check("t5_winstr", w_Instr, 32'h0010_0113);
    check("t5_wvalid", {31'd0, w_instr_valid}, 32'd1);
    w_stall = 1'b0;
    step();
    w_stall = 1'b1;
    check("t5_wrap_pc", w_PC, 32'h0);
    check("t5_wrap_cnt", w_instret, 32'd1);

    // Test 6: reset during a pending miss
    check("t6_pre_req", {31'd0, imem.req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_req_drop", {31'd0, imem.req}, 32'd0);
    check("t6_pc", PC, 32'h0);
    check("t6_valid", {31'd0, instr_valid}, 32'd0);
    check("t6_instret", instret, 32'd0);
    step();
    check("t6_req_back", {31'd0, imem.req}, 32'd1);
    check("t6_addr", imem.addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
